// File: rtl/de0_cv_system_cpu_div_cell_if.sv
// de0_cv_system_cpu_div_cell_if: divider request/result bundle; A_div_abort exists only with DIV_ABORT_EN.
interface de0_cv_system_cpu_div_cell_if #(parameter int DIV_WIDTH = 32);
  logic [DIV_WIDTH-1:0] A_div_src1;
  logic [DIV_WIDTH-1:0] A_div_src2;
  logic                 A_div_signed;
  logic                 A_div_start;
`ifdef DIV_ABORT_EN
  logic                 A_div_abort;
`endif
  logic                 A_div_busy;
  logic                 A_div_done;
  logic [DIV_WIDTH-1:0] A_div_quotient;
  logic [DIV_WIDTH-1:0] A_div_remainder;
  modport master (
`ifdef DIV_ABORT_EN
    output A_div_abort,
`endif
    output A_div_src1, A_div_src2, A_div_signed, A_div_start,
    input  A_div_busy, A_div_done, A_div_quotient, A_div_remainder
  );
  modport slave (
`ifdef DIV_ABORT_EN
    input  A_div_abort,
`endif
    input  A_div_src1, A_div_src2, A_div_signed, A_div_start,
    output A_div_busy, A_div_done, A_div_quotient, A_div_remainder
  );
endinterface

// File: rtl/de0_cv_system_cpu_div_cell.sv
// de0_cv_system_cpu_div_cell: iterative radix-2 restoring divider, signed/unsigned, latency DIV_WIDTH+2.
// Optional DIV_ABORT_EN adds A_div_abort to cancel an operation in RUN or FIX.
module de0_cv_system_cpu_div_cell #(
  parameter int DIV_WIDTH = 32
) (
  input logic                         clk,
  input logic                         reset,
  de0_cv_system_cpu_div_cell_if.slave div
);
  localparam int W  = DIV_WIDTH;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   p_q, p_d, q_q, q_d, d_q, d_d, src1_q, src1_d;
  logic [W-1:0]   quot_q, quot_d, rem_q, rem_d;
  logic           qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [W:0]     shifted, diff;
  logic           neg1, neg2, abort;
`ifdef DIV_ABORT_EN
  assign abort = div.A_div_abort;
`else
  assign abort = 1'b0;
`endif
  // P stays below D, so diff[W] is exactly the borrow of the trial subtraction
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    src1_d  = src1_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    neg1    = div.A_div_signed & div.A_div_src1[W-1];
    neg2    = div.A_div_signed & div.A_div_src2[W-1];
    shifted = {p_q, q_q[W-1]};
    diff    = shifted - {1'b0, d_q};
    case (state_q)
      IDLE: if (div.A_div_start) begin
        state_d = RUN;
        cnt_d   = CW'(W - 1);
        p_d     = '0;
        q_d     = neg1 ? -div.A_div_src1 : div.A_div_src1;
        d_d     = neg2 ? -div.A_div_src2 : div.A_div_src2;
        qneg_d  = neg1 ^ neg2;
        rneg_d  = neg1;
        src1_d  = div.A_div_src1;
        dz_d    = div.A_div_src2 == '0;
      end
      RUN: begin
        p_d     = diff[W] ? shifted[W-1:0] : diff[W-1:0];
        q_d     = {q_q[W-2:0], ~diff[W]};
        cnt_d   = cnt_q == '0 ? '0 : cnt_q - CW'(1);
        state_d = abort ? IDLE : (cnt_q == '0 ? FIX : RUN);
      end
      FIX: if (abort) state_d = IDLE;
      else begin
        state_d = DONE;
        quot_d  = dz_q ? '1 : (qneg_q ? -q_q : q_q);
        rem_d   = dz_q ? src1_q : (rneg_q ? -p_q : p_q);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      src1_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      src1_q  <= src1_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end
  assign div.A_div_busy      = state_q != IDLE;
  assign div.A_div_done      = state_q == DONE;
  assign div.A_div_quotient  = quot_q;
  assign div.A_div_remainder = rem_q;
endmodule
